// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator round-robin scheduler:
//   - calculator op encodings (add/sub/mul/div)
//   - scheduler state encoding
//   - result returned for a divide-by-zero job
//   - is_div_zero(): jobs the scheduler answers itself without the engine
// ----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_ISSUE = S_ISSUE,
        ST_WAIT  = S_WAIT,
        ST_RESP  = S_RESP
    } state_t;

    localparam logic [3:0] DIVZ_RESULT = 4'hF;

    function automatic logic is_div_zero(input logic [1:0] op, input logic [3:0] b);
        return (op == OP_DIV) && (b == 4'd0);
    endfunction

endpackage

// File: rtl/calc_rr_scheduler_if.sv
// ----------------------------------------------------------------------------
// calc_rr_scheduler_if
// Bundles the requester side and the engine side of the scheduler.
//   Requester side: req, req_a, req_b, req_op  -> scheduler
//                   grant, resp_valid, resp_data, resp_err <- scheduler
//   Engine side:    eng_start, eng_a, eng_b, eng_op <- scheduler
//                   eng_done, eng_result -> scheduler
// Modports: slave = the scheduler, master = requesters plus engine.
// ----------------------------------------------------------------------------
interface calc_rr_scheduler_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [2*N-1:0] req_op;
    logic [N-1:0]   grant;
    logic [N-1:0]   resp_valid;
    logic [3:0]     resp_data;
    logic           resp_err;
    logic           eng_start;
    logic [3:0]     eng_a;
    logic [3:0]     eng_b;
    logic [1:0]     eng_op;
    logic           eng_done;
    logic [3:0]     eng_result;

    modport master (
        output req, req_a, req_b, req_op, eng_done, eng_result,
        input  grant, resp_valid, resp_data, resp_err, eng_start, eng_a, eng_b, eng_op
    );

    modport slave (
        input  req, req_a, req_b, req_op, eng_done, eng_result,
        output grant, resp_valid, resp_data, resp_err, eng_start, eng_a, eng_b, eng_op
    );
endinterface

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. Returns the first set bit of req
// searching ptr+1, ptr+2, ... modulo N.
//   req   in  N   request vector
//   ptr   in  PW  last served index
//   valid out 1   any request set
//   index out PW  winning requester
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] index
);

    function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int k);
        return PW'((int'(base) + k) % N);
    endfunction

    always_comb begin
        valid = 1'b0;
        index = '0;
        // Scan from the farthest candidate to the nearest so the nearest one wins.
        for (int k = N; k >= 1; k--) begin
            if (req[slot(ptr, k)]) begin
                valid = 1'b1;
                index = slot(ptr, k);
            end
        end
    end

endmodule

// File: rtl/calc_rr_scheduler.sv
// ----------------------------------------------------------------------------
// calc_rr_scheduler
// Shares one 4-bit calculator engine between N requesters in round-robin
// order. A job is latched in IDLE, issued in ISSUE, completed (or timed out)
// in WAIT and returned to its owner in RESP. Divide-by-zero jobs are answered
// directly with DIVZ_RESULT and an error, without starting the engine.
//   clk     in  system clock
//   resetn  in  asynchronous active-low reset
//   bus     slave modport of calc_rr_scheduler_if (requester + engine side)
// All outputs are decoded from registers only.
// ----------------------------------------------------------------------------
module calc_rr_scheduler
    import calc_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic               clk,
    input  logic               resetn,
    calc_rr_scheduler_if.slave bus
);

    localparam int PW = $clog2(N);

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [3:0]      a_q;
    logic [3:0]      b_q;
    logic [1:0]      op_q;
    logic [3:0]      result_q;
    logic            err_q;
    logic [TW-1:0]   timer;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;
    logic            divz;
    logic            timer_last;
    logic [N-1:0]    owner_onehot;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign divz         = is_div_zero(op_q, b_q);
    assign timer_last   = (timer == TW'(TIMEOUT - 1));
    assign owner_onehot = {{(N-1){1'b0}}, 1'b1} << owner;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        // NOTE: assign a default before the case so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = divz ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (bus.eng_done || timer_last) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // result_q/err_q are written only on the way into RESP, so resp_data holds
    // the last response between jobs.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: only a handful of control/data flops, so every one gets a reset value.
        if (!resetn) begin
            ptr      <= PW'(N - 1);
            owner    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            timer    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        a_q   <= bus.req_a[{pick_idx, 2'b00} +: 4];
                        b_q   <= bus.req_b[{pick_idx, 2'b00} +: 4];
                        op_q  <= bus.req_op[{pick_idx, 1'b0} +: 2];
                    end
                end
                ST_ISSUE: begin
                    if (divz) begin
                        result_q <= DIVZ_RESULT;
                        err_q    <= 1'b1;
                    end else begin
                        timer <= '0;
                    end
                end
                ST_WAIT: begin
                    // A done pulse on the last timeout cycle still wins.
                    if (bus.eng_done) begin
                        result_q <= bus.eng_result;
                        err_q    <= 1'b0;
                    end else if (timer_last) begin
                        result_q <= 4'h0;
                        err_q    <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESP: ptr <= owner;
                default: ;
            endcase
        end
    end

    assign bus.grant      = (state == ST_ISSUE) ? owner_onehot : '0;
    assign bus.resp_valid = (state == ST_RESP)  ? owner_onehot : '0;
    assign bus.resp_data  = result_q;
    assign bus.resp_err   = (state == ST_RESP) && err_q;
    assign bus.eng_start  = (state == ST_ISSUE) && !divz;
    assign bus.eng_a      = a_q;
    assign bus.eng_b      = b_q;
    assign bus.eng_op     = op_q;

endmodule

// File: tb/tb_calc_rr_scheduler.sv
// ----------------------------------------------------------------------------
// tb_calc_rr_scheduler
// Drives random jobs from N requesters plus a configurable-latency engine
// model, and checks grant order, timing, results and errors against a
// round-robin reference model kept in the bench.
// ----------------------------------------------------------------------------
module tb_calc_rr_scheduler;

    localparam int N       = 4;
    localparam int TIMEOUT = 8;
    localparam int TW      = 7;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    calc_rr_scheduler_if #(.N(N)) bus ();

    calc_rr_scheduler #(.N(N), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Job table per requester; jd = engine delay (0 = engine never answers).
    logic [3:0] ja [N];
    logic [3:0] jb [N];
    logic [1:0] jop [N];
    int         jd [N];
    int         remaining [N];

    // Reference model state: last served index and arbitration timing.
    int m_ptr        = N - 1;
    int free_cyc     = 0;
    int last_req_cyc = 0;

    int eng_cnt    = 0;
    int eng_starts = 0;

    function automatic logic [3:0] ref_calc(input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] op);
        case (op)
            2'd0:    return 4'(a + b);
            2'd1:    return 4'(a - b);
            2'd2:    return 4'(a * b);
            default: return (b == 4'd0) ? 4'hF : 4'(a / b);
        endcase
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Engine model: done pulse D cycles after the start cycle, result from eng_* inputs.
    initial begin
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        forever begin
            @(negedge clk);
            bus.eng_done = 1'b0;
            if (!resetn) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt = eng_cnt - 1;
                    if (eng_cnt == 0) begin
                        bus.eng_done   = 1'b1;
                        bus.eng_result = ref_calc(bus.eng_a, bus.eng_b, bus.eng_op);
                    end
                end
                if (bus.eng_start === 1'b1) begin
                    eng_starts = eng_starts + 1;
                    eng_cnt    = jd[onehot_idx(bus.grant)];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_job(input int i, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input int d);
        ja[i] = a; jb[i] = b; jop[i] = op; jd[i] = d;
        bus.req_a[4*i +: 4]  = a;
        bus.req_b[4*i +: 4]  = b;
        bus.req_op[2*i +: 2] = op;
    endtask

    task automatic rand_job(input int i);
        logic [3:0] a, b;
        logic [1:0] op;
        a  = 4'($urandom);
        b  = 4'($urandom);
        op = 2'($urandom);
        if ($urandom_range(0, 5) == 0) begin op = 2'd3; b = 4'd0; end
        set_job(i, a, b, op, int'($urandom_range(0, TIMEOUT + 3)));
    endtask

    task automatic raise(input logic [N-1:0] mask);
        bus.req      = bus.req | mask;
        last_req_cyc = cyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn  = 1'b0;
        bus.req = '0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        repeat (2) @(negedge clk);
        resetn   = 1'b1;
        m_ptr    = N - 1;
        free_cyc = cyc;
    endtask

    // Serves the job the model predicts next and compares every observable.
    task automatic serve_next(input string tag, output int who);
        int w, eg, er;
        bit got, glitch, dz;
        logic [3:0]   ed;
        logic         ee;
        logic [N-1:0] exp_vec;
        w = -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        who = -1;
        eg  = ((last_req_cyc > free_cyc) ? last_req_cyc : free_cyc) + 1;
        got = 1'b0;
        for (int t = 0; t < 32 && !got; t++) begin
            @(negedge clk);
            got = (bus.grant != '0);
        end
        n_checks++;
        if (!got || w < 0) begin
            n_fail++;
            $display("FAIL %s grant_seen: got none, required requester %0d", tag, w);
            return;
        end
        who     = onehot_idx(bus.grant);
        exp_vec = '0;
        exp_vec[w] = 1'b1;
        n_checks++;
        if (bus.grant !== exp_vec) begin
            n_fail++; $display("FAIL %s grant: got %b, required %b", tag, bus.grant, exp_vec);
        end
        n_checks++;
        if (cyc !== eg) begin
            n_fail++; $display("FAIL %s grant_cycle: got %0d, required %0d", tag, cyc, eg);
        end
        dz = (jop[w] == 2'd3) && (jb[w] == 4'd0);
        n_checks++;
        if (bus.eng_start !== !dz) begin
            n_fail++; $display("FAIL %s eng_start: got %b, required %b", tag, bus.eng_start, !dz);
        end
        if (!dz) begin
            n_checks++;
            if ({bus.eng_a, bus.eng_b, bus.eng_op} !== {ja[w], jb[w], jop[w]}) begin
                n_fail++;
                $display("FAIL %s eng_operands: got %h/%h/%0d, required %h/%h/%0d", tag,
                         bus.eng_a, bus.eng_b, bus.eng_op, ja[w], jb[w], jop[w]);
            end
        end
        // The in-flight job must be immune to operand changes on the bus.
        bus.req_a[4*w +: 4]  = 4'($urandom);
        bus.req_b[4*w +: 4]  = 4'($urandom);
        bus.req_op[2*w +: 2] = 2'($urandom);
        if (dz) begin
            er = cyc + 1; ed = 4'hF; ee = 1'b1;
        end else if (jd[w] >= 1 && jd[w] <= TIMEOUT) begin
            er = cyc + 1 + jd[w]; ed = ref_calc(ja[w], jb[w], jop[w]); ee = 1'b0;
        end else begin
            er = cyc + 1 + TIMEOUT; ed = 4'h0; ee = 1'b1;
        end
        got    = 1'b0;
        glitch = 1'b0;
        for (int t = 0; t < TIMEOUT + 8 && !got; t++) begin
            @(negedge clk);
            if (bus.resp_valid != '0) got = 1'b1;
            else if (bus.grant != '0 || bus.resp_err !== 1'b0) glitch = 1'b1;
        end
        n_checks++;
        if (glitch) begin
            n_fail++; $display("FAIL %s quiet_wait: grant or resp_err seen before response", tag);
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL %s resp_seen: got none, required at cycle %0d", tag, er);
            return;
        end
        n_checks++;
        if (bus.resp_valid !== exp_vec) begin
            n_fail++; $display("FAIL %s resp_valid: got %b, required %b", tag, bus.resp_valid, exp_vec);
        end
        n_checks++;
        if (cyc !== er) begin
            n_fail++; $display("FAIL %s resp_cycle: got %0d, required %0d", tag, cyc, er);
        end
        n_checks++;
        if (bus.resp_data !== ed) begin
            n_fail++; $display("FAIL %s resp_data: got %h, required %h", tag, bus.resp_data, ed);
        end
        n_checks++;
        if (bus.resp_err !== ee) begin
            n_fail++; $display("FAIL %s resp_err: got %b, required %b", tag, bus.resp_err, ee);
        end
        m_ptr    = w;
        free_cyc = cyc + 1;
        remaining[w]--;
        if (remaining[w] > 0) rand_job(w);
        else                  bus.req[w] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.resp_valid !== '0 || bus.resp_err !== 1'b0 || bus.resp_data !== ed) begin
            n_fail++;
            $display("FAIL %s resp_after: valid %b err %b data %h, required 0 0 %h", tag,
                     bus.resp_valid, bus.resp_err, bus.resp_data, ed);
        end
    endtask

    task automatic serve_all(input string tag);
        int who;
        for (int j = 0; j < 64 && bus.req != '0; j++) serve_next(tag, who);
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.grant, bus.resp_valid, bus.eng_start, bus.resp_err} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b/%b/%b/%b, required zeros",
                               bus.grant, bus.resp_valid, bus.eng_start, bus.resp_err);
        end
        n_checks++;
        if ({bus.resp_data, bus.eng_a, bus.eng_b, bus.eng_op} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h/%0d, required zeros",
                               bus.resp_data, bus.eng_a, bus.eng_b, bus.eng_op);
        end
        resetn   = 1'b1;
        m_ptr    = N - 1;
        free_cyc = cyc;
    endtask

    task automatic test_single();
        int who;
        remaining[0] = 1;
        set_job(0, 4'd5, 4'd3, 2'd0, 3);
        raise(4'b0001);
        serve_next("single", who);
    endtask

    task automatic test_divz();
        int who, s0;
        remaining[2] = 1;
        set_job(2, 4'd9, 4'd0, 2'd3, 3);
        s0 = eng_starts;
        raise(4'b0100);
        serve_next("divz", who);
        n_checks++;
        if (eng_starts !== s0) begin
            n_fail++; $display("FAIL divz_no_start: got %0d starts, required 0", eng_starts - s0);
        end
    endtask

    task automatic test_contention();
        int order [4];
        int exp_order [4] = '{0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 3; i++) set_job(i, 4'($urandom), 4'($urandom_range(1, 15)), 2'($urandom), 2);
        remaining[0] = 2; remaining[1] = 1; remaining[2] = 1;
        raise(4'b0111);
        for (int j = 0; j < 4; j++) serve_next("contention", order[j]);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (order[j] !== exp_order[j]) begin
                n_fail++; $display("FAIL contention_order[%0d]: got %0d, required %0d", j, order[j], exp_order[j]);
            end
        end
    endtask

    task automatic test_timeout();
        remaining[1] = 1; remaining[3] = 1;
        set_job(1, 4'd6, 4'd7, 2'd0, 0);
        set_job(3, 4'd2, 4'd3, 2'd2, 4);
        raise(4'b1010);
        serve_all("timeout");
    endtask

    task automatic test_done_last();
        remaining[3] = 1;
        set_job(3, 4'd9, 4'd4, 2'd1, TIMEOUT);
        raise(4'b1000);
        serve_all("done_last");
        remaining[3] = 1;
        set_job(3, 4'd9, 4'd4, 2'd1, TIMEOUT + 1);
        raise(4'b1000);
        serve_all("done_late");
    endtask

    task automatic test_reset_mid();
        int who;
        bit got;
        remaining[0] = 1;
        set_job(0, 4'd7, 4'd2, 2'd2, 0);
        raise(4'b0001);
        got = 1'b0;
        for (int t = 0; t < 16 && !got; t++) begin
            @(negedge clk);
            got = (bus.grant != '0);
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL reset_mid_grant: got none, required requester 0");
        end
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.grant, bus.resp_valid, bus.eng_start, bus.resp_err} !== '0) begin
            n_fail++; $display("FAIL reset_mid_ctrl: got %b/%b/%b/%b, required zeros",
                               bus.grant, bus.resp_valid, bus.eng_start, bus.resp_err);
        end
        n_checks++;
        if ({bus.resp_data, bus.eng_a, bus.eng_b, bus.eng_op} !== '0) begin
            n_fail++; $display("FAIL reset_mid_data: got %h/%h/%h/%0d, required zeros",
                               bus.resp_data, bus.eng_a, bus.eng_b, bus.eng_op);
        end
        @(negedge clk);
        bus.req = '0;
        for (int i = 0; i < N; i++) remaining[i] = 0;
        set_job(0, 4'd3, 4'd4, 2'd0, 2);
        set_job(1, 4'd5, 4'd5, 2'd1, 1);
        remaining[0] = 1; remaining[1] = 1;
        @(negedge clk);
        resetn   = 1'b1;
        m_ptr    = N - 1;
        free_cyc = cyc;
        raise(4'b0011);
        serve_next("reset_mid", who);
        n_checks++;
        if (who !== 0) begin
            n_fail++; $display("FAIL reset_mid_first: got requester %0d, required 0", who);
        end
        serve_all("reset_mid");
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        for (int r = 0; r < 6; r++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    remaining[i] = int'($urandom_range(1, 3));
                    rand_job(i);
                end
            end
            raise(mask);
            serve_all("random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_divz();
        test_contention();
        test_timeout();
        test_done_last();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
